// File: rtl/bp_cacc_pkg.sv
// Shared types for the dot-product accelerator job sequencer: memory message format,
// accelerator CSR map, sequencer state and completion codes.
package bp_cacc_pkg;

  typedef enum logic [1:0] {
    e_bp_inv_cfg     = 2'd0,
    e_bp_default_cfg = 2'd1
  } bp_params_e;

  localparam int unsigned paddr_width_p       = 40;
  localparam int unsigned dword_width_p       = 64;
  localparam int unsigned mem_payload_width_p = 16;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3
  } bp_cce_mem_msg_type_e;

  typedef enum logic [2:0] {
    e_mem_size_1  = 3'd0,
    e_mem_size_2  = 3'd1,
    e_mem_size_4  = 3'd2,
    e_mem_size_8  = 3'd3,
    e_mem_size_16 = 3'd4,
    e_mem_size_32 = 3'd5,
    e_mem_size_64 = 3'd6
  } bp_mem_msg_size_e;

  typedef struct packed {
    bp_cce_mem_msg_type_e             msg_type;
    bp_mem_msg_size_e                 size;
    logic [paddr_width_p-1:0]         addr;
    logic [mem_payload_width_p-1:0]   payload;
    logic [dword_width_p-1:0]         data;
  } bp_cce_mem_msg_s;

  localparam int unsigned cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

  // Accelerator CSR offsets
  localparam logic [11:0] CaccAPtrOff   = 12'h000;
  localparam logic [11:0] CaccBPtrOff   = 12'h040;
  localparam logic [11:0] CaccLenOff    = 12'h080;
  localparam logic [11:0] CaccStartOff  = 12'h0C0;
  localparam logic [11:0] CaccStatusOff = 12'h100;
  localparam logic [11:0] CaccResPtrOff = 12'h140;
  localparam logic [11:0] CaccResLenOff = 12'h180;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSend     = 3'd1,
    StWaitResp = 3'd2,
    StGap      = 3'd3,
    StReport   = 3'd4
  } cacc_state_e;

  typedef enum logic [1:0] {
    DoneOk      = 2'd0,
    DoneBadLen  = 2'd1,
    DoneTimeout = 2'd2
  } cacc_done_e;

  typedef enum logic [2:0] {
    SelAPtr   = 3'd0,
    SelBPtr   = 3'd1,
    SelLen    = 3'd2,
    SelResPtr = 3'd3,
    SelOne    = 3'd4
  } cacc_data_sel_e;

  function automatic int unsigned bp_cfg_paddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return paddr_width_p;
      default:          return paddr_width_p;
    endcase
  endfunction

endpackage

// File: rtl/bp_cacc_seq_step_rom.sv
// Write-sequence table: step index to CSR offset and data source. Retarget the
// accelerator's programming order by editing this table only.
module bp_cacc_seq_step_rom
  import bp_cacc_pkg::*;
(
  input  logic [2:0]     step_i,
  output logic [11:0]    offset_o,
  output cacc_data_sel_e data_sel_o,
  output logic           last_o
);

  always_comb begin
    offset_o   = CaccAPtrOff;
    data_sel_o = SelAPtr;
    last_o     = 1'b0;
    case (step_i)
      3'd0: begin offset_o = CaccAPtrOff;   data_sel_o = SelAPtr;   end
      3'd1: begin offset_o = CaccBPtrOff;   data_sel_o = SelBPtr;   end
      3'd2: begin offset_o = CaccLenOff;    data_sel_o = SelLen;    end
      3'd3: begin offset_o = CaccResPtrOff; data_sel_o = SelResPtr; end
      3'd4: begin offset_o = CaccResLenOff; data_sel_o = SelOne;    end
      3'd5: begin offset_o = CaccStartOff;  data_sel_o = SelOne; last_o = 1'b1; end
      default: begin offset_o = CaccAPtrOff; data_sel_o = SelAPtr; end
    endcase
  end

endmodule

// File: rtl/bp_cacc_vdp_seq.sv
// Job sequencer for the vector dot-product accelerator: programs the CSRs, polls status,
// returns a completion token. Define BP_CACC_SEQ_TIMEOUT_EN to bound polling by max_polls_p.
module bp_cacc_vdp_seq
  import bp_cacc_pkg::*;
#(
  parameter bp_params_e               bp_params_p      = e_bp_inv_cfg,
  parameter logic [paddr_width_p-1:0] cacc_base_addr_p = 40'h0,
  parameter int unsigned              poll_gap_p       = 16,
  parameter int unsigned              max_polls_p      = 1024
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            job_v_i,
  output logic                            job_ready_o,
  input  logic [63:0]                     job_a_ptr_i,
  input  logic [63:0]                     job_b_ptr_i,
  input  logic [3:0]                      job_len_i,
  input  logic [63:0]                     job_res_ptr_i,
  output logic [cce_mem_msg_width_lp-1:0] io_cmd_o,
  output logic                            io_cmd_v_o,
  input  logic                            io_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0] io_resp_i,
  input  logic                            io_resp_v_i,
  output logic                            io_resp_yumi_o,
  output logic                            done_v_o,
  output logic [1:0]                      done_err_o,
  input  logic                            done_ready_i
);

  localparam int unsigned PaddrW = bp_cfg_paddr_width(bp_params_p);
  localparam int unsigned GapW   = $clog2(poll_gap_p + 1);

  cacc_state_e     r_state, w_state_nxt;
  logic [2:0]      r_step, w_step_nxt;
  logic            r_poll, w_poll_nxt;
  logic            r_busy_seen, w_busy_seen_nxt;
  logic            r_nz_prev, w_nz_prev_nxt;
  logic [GapW-1:0] r_gap_cnt, w_gap_cnt_nxt;
  cacc_done_e      r_err, w_err_nxt;
  logic [63:0]     r_a_ptr, r_b_ptr, r_res_ptr;
  logic [3:0]      r_len;

  logic            w_job_acc, w_cmd_fire, w_bad_len, w_status_nz, w_poll_timeout;
  logic [11:0]     w_rom_offset;
  cacc_data_sel_e  w_rom_sel;
  logic            w_rom_last;
  bp_cce_mem_msg_s w_cmd, w_resp;
  logic            w_unused_resp;

  assign w_job_acc   = job_v_i & (r_state == StIdle);
  assign w_cmd_fire  = io_cmd_v_o & io_cmd_ready_i;
  assign w_bad_len   = (job_len_i == 4'd0) || (job_len_i > 4'd8);
  assign w_resp      = io_resp_i;
  assign w_status_nz = |w_resp.data;
  assign w_unused_resp = ^{w_resp.msg_type, w_resp.size, w_resp.addr, w_resp.payload};

`ifdef BP_CACC_SEQ_TIMEOUT_EN
  localparam int unsigned PollW = $clog2(max_polls_p + 1);
  logic [PollW-1:0] r_poll_cnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_poll_cnt <= '0;
    end else if ((r_state == StReport) && done_ready_i) begin
      r_poll_cnt <= '0;
    end else if (w_cmd_fire && r_poll) begin
      r_poll_cnt <= r_poll_cnt + PollW'(1);
    end
  end

  assign w_poll_timeout = (r_poll_cnt == PollW'(max_polls_p));
`else
  localparam int unsigned unused_max_polls = max_polls_p;
  assign w_poll_timeout = 1'b0;
`endif

  bp_cacc_seq_step_rom u_step_rom (
    .step_i     (r_step),
    .offset_o   (w_rom_offset),
    .data_sel_o (w_rom_sel),
    .last_o     (w_rom_last)
  );

  // Built purely from registers, so the command holds while the accelerator stalls.
  always_comb begin
    w_cmd         = '0;
    w_cmd.size    = e_mem_size_8;
    w_cmd.payload = '0;
    if (r_poll) begin
      w_cmd.msg_type = e_cce_mem_uc_rd;
      w_cmd.addr     = cacc_base_addr_p | PaddrW'(CaccStatusOff);
    end else begin
      w_cmd.msg_type = e_cce_mem_uc_wr;
      w_cmd.addr     = cacc_base_addr_p | PaddrW'(w_rom_offset);
      unique case (w_rom_sel)
        SelAPtr:   w_cmd.data = r_a_ptr;
        SelBPtr:   w_cmd.data = r_b_ptr;
        SelLen:    w_cmd.data = {60'd0, r_len};
        SelResPtr: w_cmd.data = r_res_ptr;
        SelOne:    w_cmd.data = 64'd1;
        default:   w_cmd.data = '0;
      endcase
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_step_nxt      = r_step;
    w_poll_nxt      = r_poll;
    w_busy_seen_nxt = r_busy_seen;
    w_nz_prev_nxt   = r_nz_prev;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_err_nxt       = r_err;
    unique case (r_state)
      StIdle: begin
        if (job_v_i) begin
          w_step_nxt = '0;
          w_poll_nxt = 1'b0;
          if (w_bad_len) begin
            w_state_nxt = StReport;
            w_err_nxt   = DoneBadLen;
          end else begin
            w_state_nxt = StSend;
            w_err_nxt   = DoneOk;
          end
        end
      end
      StSend: begin
        if (io_cmd_ready_i) w_state_nxt = StWaitResp;
      end
      StWaitResp: begin
        if (io_resp_v_i) begin
          if (!r_poll) begin
            if (w_rom_last) begin
              w_state_nxt   = StGap;
              w_gap_cnt_nxt = GapW'(poll_gap_p);
            end else begin
              w_step_nxt  = r_step + 3'd1;
              w_state_nxt = StSend;
            end
          end else if (w_status_nz && (r_busy_seen || r_nz_prev)) begin
            // Nonzero after busy, or two nonzero in a row when the job beat the first poll.
            w_state_nxt = StReport;
            w_err_nxt   = DoneOk;
          end else if (w_poll_timeout) begin
            w_state_nxt = StReport;
            w_err_nxt   = DoneTimeout;
          end else begin
            w_busy_seen_nxt = r_busy_seen | ~w_status_nz;
            w_nz_prev_nxt   = w_status_nz;
            w_state_nxt     = StGap;
            w_gap_cnt_nxt   = GapW'(poll_gap_p);
          end
        end
      end
      StGap: begin
        if (r_gap_cnt <= GapW'(1)) begin
          w_gap_cnt_nxt = '0;
          w_poll_nxt    = 1'b1;
          w_state_nxt   = StSend;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GapW'(1);
        end
      end
      StReport: begin
        if (done_ready_i) begin
          w_state_nxt     = StIdle;
          w_busy_seen_nxt = 1'b0;
          w_nz_prev_nxt   = 1'b0;
          w_poll_nxt      = 1'b0;
          w_step_nxt      = '0;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= StIdle;
      r_step      <= '0;
      r_poll      <= 1'b0;
      r_busy_seen <= 1'b0;
      r_nz_prev   <= 1'b0;
      r_gap_cnt   <= '0;
      r_err       <= DoneOk;
    end else begin
      r_state     <= w_state_nxt;
      r_step      <= w_step_nxt;
      r_poll      <= w_poll_nxt;
      r_busy_seen <= w_busy_seen_nxt;
      r_nz_prev   <= w_nz_prev_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_err       <= w_err_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_a_ptr   <= '0;
      r_b_ptr   <= '0;
      r_res_ptr <= '0;
      r_len     <= '0;
    end else if (w_job_acc) begin
      r_a_ptr   <= job_a_ptr_i;
      r_b_ptr   <= job_b_ptr_i;
      r_res_ptr <= job_res_ptr_i;
      r_len     <= job_len_i;
    end
  end

  assign job_ready_o    = (r_state == StIdle);
  assign io_cmd_o       = w_cmd;
  assign io_cmd_v_o     = (r_state == StSend);
  assign io_resp_yumi_o = io_resp_v_i & (r_state == StWaitResp);
  assign done_v_o       = (r_state == StReport);
  assign done_err_o     = r_err;

  a_resp_only_in_wait: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    io_resp_v_i |-> (r_state == StWaitResp));

endmodule

// File: tb/tb_bp_cacc_vdp_seq.sv
// Directed bench for bp_cacc_vdp_seq: table of jobs plus stall, timeout and mid-job reset cases.
module tb_bp_cacc_vdp_seq;
  import bp_cacc_pkg::*;

  localparam logic [39:0] Base = 40'h00_4000_0000;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  len;
    logic [63:0] res;
    logic [7:0]  st;       // bit i: poll i reads nz_val, else 0; polls past 8 read 0
    logic [63:0] nz_val;
    logic [1:0]  exp_err;
    int          exp_polls;
  } job_vec_t;

  logic clk = 1'b0;
  logic reset_n_i;
  logic job_v_i, job_ready_o;
  logic [63:0] job_a_ptr_i, job_b_ptr_i, job_res_ptr_i;
  logic [3:0] job_len_i;
  logic [cce_mem_msg_width_lp-1:0] io_cmd_o, io_resp_i;
  logic io_cmd_v_o, io_cmd_ready_i, io_resp_v_i, io_resp_yumi_o;
  logic done_v_o, done_ready_i;
  logic [1:0] done_err_o;

  int n_checks = 0;
  int n_errors = 0;

  bp_cce_mem_msg_s log_q[$];
  logic [7:0]  st_bits;
  logic [63:0] nz_val;
  int poll_idx, n_resp, n_v_cycles;
  int stall_left, stall_seen, stall_bad;
  logic [11:0] stall_off;
  logic [63:0] stall_data;
  bit pend;
  logic [63:0] pend_data;

  logic [11:0] exp_off [6] = '{12'h000, 12'h040, 12'h080, 12'h140, 12'h180, 12'h0C0};

  always #5 clk = ~clk;

  bp_cacc_vdp_seq #(
    .cacc_base_addr_p (Base),
    .poll_gap_p       (3),
    .max_polls_p      (4)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n_i),
    .job_v_i        (job_v_i),
    .job_ready_o    (job_ready_o),
    .job_a_ptr_i    (job_a_ptr_i),
    .job_b_ptr_i    (job_b_ptr_i),
    .job_len_i      (job_len_i),
    .job_res_ptr_i  (job_res_ptr_i),
    .io_cmd_o       (io_cmd_o),
    .io_cmd_v_o     (io_cmd_v_o),
    .io_cmd_ready_i (io_cmd_ready_i),
    .io_resp_i      (io_resp_i),
    .io_resp_v_i    (io_resp_v_i),
    .io_resp_yumi_o (io_resp_yumi_o),
    .done_v_o       (done_v_o),
    .done_err_o     (done_err_o),
    .done_ready_i   (done_ready_i)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Accelerator model: optional ready stall on one offset, response one cycle after WAIT_RESP.
  always begin : responder
    bp_cce_mem_msg_s m;
    bit cmd_fire, resp_fire;
    @(negedge clk);
    m = io_cmd_o;
    if (io_cmd_v_o && stall_left > 0 && m.addr[11:0] == stall_off) begin
      io_cmd_ready_i = 1'b0;
      stall_left--;
      stall_seen++;
      if (m.addr != (Base | 40'(stall_off)) || m.data != stall_data) stall_bad++;
    end else begin
      io_cmd_ready_i = 1'b1;
    end
    if (io_cmd_v_o) n_v_cycles++;
    cmd_fire  = io_cmd_v_o && io_cmd_ready_i;
    resp_fire = io_resp_v_i && io_resp_yumi_o;
    if (resp_fire) n_resp++;
    if (cmd_fire) log_q.push_back(m);
    @(posedge clk);
    #1;
    if (resp_fire) io_resp_v_i = 1'b0;
    if (pend) begin
      pend = 1'b0;
      io_resp_v_i = 1'b1;
      io_resp_i = {4'(e_cce_mem_uc_wr), 3'(e_mem_size_8), 40'd0, 16'd0, pend_data};
    end
    if (cmd_fire) begin
      pend = 1'b1;
      if (m.msg_type == e_cce_mem_uc_rd) begin
        pend_data = (poll_idx < 8 && st_bits[poll_idx]) ? nz_val : 64'd0;
        poll_idx++;
      end else begin
        pend_data = 64'hFFFF_0000_FFFF;
      end
    end
    if (!reset_n_i) begin
      pend = 1'b0;
      io_resp_v_i = 1'b0;
    end
  end

  task automatic clear_log();
    log_q.delete();
    poll_idx = 0;
    n_resp = 0;
    n_v_cycles = 0;
  endtask

  task automatic run_job(input job_vec_t v, input string tag);
    bit legal;
    int cyc, n_wr, n_rd;
    logic [63:0] exp_d [6];
    bp_cce_mem_msg_s m;
    legal = (v.len != 4'd0) && (v.len <= 4'd8);
    exp_d = '{v.a, v.b, {60'd0, v.len}, v.res, 64'd1, 64'd1};
    st_bits = v.st;
    nz_val = v.nz_val;
    @(negedge clk);
    clear_log();
    check({tag, ".ready"}, 64'(job_ready_o), 64'd1);
    job_v_i = 1'b1; job_a_ptr_i = v.a; job_b_ptr_i = v.b;
    job_len_i = v.len; job_res_ptr_i = v.res;
    @(posedge clk);
    #1;
    job_v_i = 1'b0;
    @(negedge clk);
    check({tag, ".cmd_v_lat"}, 64'(io_cmd_v_o), 64'(legal));
    check({tag, ".done_lat"}, 64'(done_v_o), 64'(!legal));
    cyc = 0;
    while (!done_v_o && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".done_seen"}, 64'(done_v_o), 64'd1);
    check({tag, ".err"}, 64'(done_err_o), 64'(v.exp_err));
    repeat (2) @(negedge clk);
    check({tag, ".done_hold"}, 64'(done_v_o), 64'd1);
    check({tag, ".err_hold"}, 64'(done_err_o), 64'(v.exp_err));
    done_ready_i = 1'b1;
    @(posedge clk);
    #1;
    done_ready_i = 1'b0;
    @(negedge clk);
    check({tag, ".done_clr"}, 64'(done_v_o), 64'd0);
    check({tag, ".idle"}, 64'(job_ready_o), 64'd1);
    if (!legal) check({tag, ".no_cmd_v"}, 64'(n_v_cycles), 64'd0);
    n_wr = 0;
    n_rd = 0;
    foreach (log_q[i]) begin
      if (log_q[i].msg_type == e_cce_mem_uc_wr) n_wr++;
      else if (log_q[i].msg_type == e_cce_mem_uc_rd) n_rd++;
    end
    check({tag, ".n_wr"}, 64'(n_wr), legal ? 64'd6 : 64'd0);
    check({tag, ".n_rd"}, 64'(n_rd), 64'(v.exp_polls));
    for (int i = 0; i < log_q.size(); i++) begin
      m = log_q[i];
      check($sformatf("%s.c%0d.size", tag, i), 64'(m.size), 64'(e_mem_size_8));
      check($sformatf("%s.c%0d.pl", tag, i), 64'(m.payload), 64'd0);
      if (i < 6) begin
        check($sformatf("%s.c%0d.type", tag, i), 64'(m.msg_type), 64'(e_cce_mem_uc_wr));
        check($sformatf("%s.c%0d.addr", tag, i), 64'(m.addr), 64'(Base | 40'(exp_off[i])));
        check($sformatf("%s.c%0d.data", tag, i), m.data, exp_d[i]);
      end else begin
        check($sformatf("%s.c%0d.type", tag, i), 64'(m.msg_type), 64'(e_cce_mem_uc_rd));
        check($sformatf("%s.c%0d.addr", tag, i), 64'(m.addr), 64'(Base | 40'h100));
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    job_vec_t vecs[8];
    job_vec_t sv;
    int cyc;
    reset_n_i = 1'b0;
    job_v_i = 1'b0; job_a_ptr_i = '0; job_b_ptr_i = '0; job_len_i = '0; job_res_ptr_i = '0;
    io_cmd_ready_i = 1'b1; io_resp_v_i = 1'b0; io_resp_i = '0; done_ready_i = 1'b0;
    st_bits = '0; nz_val = 64'd1; pend = 1'b0; pend_data = '0;
    stall_left = 0; stall_seen = 0; stall_bad = 0; stall_off = 12'hFFF; stall_data = '0;
    clear_log();

    vecs[0] = '{64'h8000_1000, 64'h8000_2000, 4'd4, 64'h8000_3000, 8'b0000_1000, 64'd1, 2'd0, 4};
    vecs[1] = '{64'h11, 64'h22, 4'd0, 64'h33, 8'h00, 64'd1, 2'd1, 0};
    vecs[2] = '{64'h11, 64'h22, 4'd9, 64'h33, 8'h00, 64'd1, 2'd1, 0};
    vecs[3] = '{64'hA5A5_0000_1111_2222, 64'h5A5A_0000_3333_4444, 4'd8, 64'hFEED_0000_0000_0008,
                8'b0000_0011, 64'h8000_0000_0000_0000, 2'd0, 2};
    vecs[4] = '{64'h100, 64'h200, 4'd1, 64'h300, 8'b0000_0010, 64'd1, 2'd0, 2};
    vecs[5] = '{64'h100, 64'h200, 4'd15, 64'h300, 8'h00, 64'd1, 2'd1, 0};
    vecs[6] = '{64'h1234, 64'h5678, 4'd3, 64'h9ABC, 8'b0000_0101, 64'd7, 2'd0, 3};
`ifdef BP_CACC_SEQ_TIMEOUT_EN
    vecs[7] = '{64'h40, 64'h80, 4'd2, 64'hC0, 8'h00, 64'd1, 2'd2, 4};
`else
    vecs[7] = '{64'h40, 64'h80, 4'd2, 64'hC0, 8'b1000_0000, 64'd1, 2'd0, 8};
`endif

    repeat (3) @(negedge clk);
    check("rst.job_ready", 64'(job_ready_o), 64'd1);
    check("rst.cmd_v", 64'(io_cmd_v_o), 64'd0);
    check("rst.yumi", 64'(io_resp_yumi_o), 64'd0);
    check("rst.done_v", 64'(done_v_o), 64'd0);
    check("rst.done_err", 64'(done_err_o), 64'd0);
    reset_n_i = 1'b1;
    @(negedge clk);
    check("rst.post_release_idle", 64'(job_ready_o), 64'd1);

    for (int i = 0; i < 8; i++) run_job(vecs[i], $sformatf("v%0d", i));

    // Length write stalled 5 cycles by the accelerator.
    sv = '{64'hB000, 64'hC000, 4'd5, 64'hD000, 8'b0000_0011, 64'd1, 2'd0, 2};
    stall_off = 12'h080; stall_data = 64'd5; stall_seen = 0; stall_bad = 0; stall_left = 5;
    run_job(sv, "stall");
    check("stall.cycles", 64'(stall_seen), 64'd5);
    check("stall.unstable", 64'(stall_bad), 64'd0);
    stall_left = 0;

    // Asynchronous reset while waiting between polls.
    sv = '{64'hE000, 64'hE100, 4'd6, 64'hE200, 8'b0000_0011, 64'd1, 2'd0, 2};
    st_bits = sv.st;
    @(negedge clk);
    clear_log();
    job_v_i = 1'b1; job_a_ptr_i = sv.a; job_b_ptr_i = sv.b;
    job_len_i = sv.len; job_res_ptr_i = sv.res;
    @(posedge clk);
    #1;
    job_v_i = 1'b0;
    cyc = 0;
    while (n_resp < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("gaprst.reached", 64'(n_resp), 64'd6);
    @(negedge clk);
    check("gaprst.quiet_cmd", 64'(io_cmd_v_o), 64'd0);
    check("gaprst.quiet_resp", 64'(io_resp_v_i), 64'd0);
    reset_n_i = 1'b0;
    @(negedge clk);
    check("gaprst.ready", 64'(job_ready_o), 64'd1);
    check("gaprst.cmd_v", 64'(io_cmd_v_o), 64'd0);
    check("gaprst.done_v", 64'(done_v_o), 64'd0);
    @(negedge clk);
    reset_n_i = 1'b1;
    n_v_cycles = 0;
    repeat (12) @(negedge clk);
    check("gaprst.no_stray_cmd", 64'(n_v_cycles), 64'd0);
    check("gaprst.still_idle", 64'(job_ready_o), 64'd1);
    check("gaprst.no_done", 64'(done_v_o), 64'd0);
    run_job(vecs[0], "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bp_cacc_vdp_seq.md
# bp_cacc_vdp_seq

Job sequencer directly upstream of the vector dot-product accelerator. It accepts one dot-product job descriptor from a local master (a core-side command queue or the test harness) and drives the accelerator's uncached CSR port in order: the operand pointers, the length, the result pointer, then start. It then polls the status CSR until the job completes and returns a completion or error token. It keeps exactly one I/O command outstanding at a time.

## Interface
Parameters:
- bp_params_p, e_bp_inv_cfg, processor configuration; supplies paddr_width_p and cce_mem_msg_width_lp
- cacc_base_addr_p, 40'h0, physical base of the accelerator CSR window; OR'd with the CSR offset
- poll_gap_p, 16, idle cycles between a status response and the next status read; must be 1 or more
- max_polls_p, 1024, poll limit; used only when the timeout feature is compiled in

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- job_v_i  in  1  job descriptor valid
- job_ready_o  out  1  high only in IDLE
- job_a_ptr_i  in  64  vector A base address
- job_b_ptr_i  in  64  vector B base address
- job_len_i  in  4  element count; legal range 1..8
- job_res_ptr_i  in  64  result address
- io_cmd_o  out  cce_mem_msg_width_lp  bp_cce_mem_msg_s going to the accelerator
- io_cmd_v_o  out  1  command valid
- io_cmd_ready_i  in  1  accelerator ready
- io_resp_i  in  cce_mem_msg_width_lp  accelerator response
- io_resp_v_i  in  1  response valid
- io_resp_yumi_o  out  1  response consumed
- done_v_o  out  1  completion token valid
- done_err_o  out  2  completion code: 0 = ok, 1 = bad length, 2 = timeout
- done_ready_i  in  1  consumer accepts the token

## Operation
Every command uses size e_mem_size_8, payload '0, and address cacc_base_addr_p | offset.

Write sequence. Each step uses msg_type e_cce_mem_uc_wr. The step index is held in a 3-bit counter.
- Step 0: offset 0x000, data a_ptr
- Step 1: offset 0x040, data b_ptr
- Step 2: offset 0x080, data zero-extended len
- Step 3: offset 0x140, data res_ptr
- Step 4: offset 0x180, data 1 (res_len)
- Step 5: offset 0x0C0, data 1 (start)

Status polls read offset 0x100 using e_cce_mem_uc_rd. A status of 0 means busy; any nonzero value means idle or finished.

Completion rule:
- A nonzero status read after at least one busy read completes the job with code 0.
- Two consecutive nonzero reads with no busy read ever seen also complete the job with code 0. This covers a job that finishes inside the first poll gap.

State machine:
- IDLE: job_ready_o = 1. When job_v_i & job_ready_o:
  - latch the descriptor;
  - if len is 0 or greater than 8, go to REPORT with code 1 and issue no commands;
  - otherwise go to SEND with step = 0.
- SEND: io_cmd_v_o = 1. On io_cmd_ready_i, go to WAIT_RESP.
- WAIT_RESP: io_resp_yumi_o = io_resp_v_i. On that consumption:
  - if the step was a write below 5, increment the step and go to SEND;
  - if the step was 5, go to GAP;
  - if the command was a poll, evaluate the completion rule; go to REPORT when it is met, otherwise to GAP.
- GAP: down-count from poll_gap_p to 0, then go to SEND with the poll command selected.
- REPORT: done_v_o = 1. On done_ready_i, go to IDLE and clear the busy-seen flag and the poll count.

Other rules:
- Response contents on write steps are ignored; the response only paces the sequence.
- A response arriving outside WAIT_RESP is a protocol error. It is not consumed, and an assertion fires.
- Asynchronous reset mid-job: state returns to IDLE and the descriptor is dropped. The accelerator's state is not repaired; the accelerator shares the same reset domain.

## Timing
Reset values:
- job_ready_o = 1
- io_cmd_v_o, io_resp_yumi_o, done_v_o = 0
- done_err_o = 0
- all counters = 0

Latency:
- A legal job's command 0 is valid on the cycle after acceptance.
- With a zero-latency ready and a one-cycle response, each write takes 3 cycles: SEND, WAIT_RESP, then the response.
- A bad-length job produces done_v_o one cycle after acceptance.

Handshake rules:
- io_cmd_o is held stable while io_cmd_v_o is high and io_cmd_ready_i is low.
- io_resp_yumi_o is combinational from io_resp_v_i, gated by state.
- done_v_o stays high until done_ready_i; done_err_o stays stable throughout.

## Configuration
BP_CACC_SEQ_TIMEOUT_EN:
- Defined: a poll counter of width $clog2(max_polls_p+1) increments on each poll issue. When the count reaches max_polls_p without completion, the block goes to REPORT with code 2.
- Undefined: polling is unbounded and code 2 never occurs.

## Structure
- The shared package (bp_cacc_pkg) holds:
  - CSR offset localparams;
  - the state enum;
  - the done-code enum.
- Commands are formed with the existing bp_cce_mem_msg_s structs.
- One sub-module, bp_cacc_seq_step_rom: a combinational step-index to {offset, data select} table, so the write order can be retargeted to other accelerators.

## Test plan
- Legal job (a=0x8000_1000, b=0x8000_2000, len=4, res=0x8000_3000), one-cycle responder, status reads 0 for 3 polls then 1: exactly 6 writes at offsets 0x000/0x040/0x080/0x140/0x180/0x0C0 with matching data, then 4 reads of 0x100, then done_v_o with code 0.
- len=0, and separately len=9: no io_cmd_v_o at all; done_err_o=1 one cycle after acceptance.
- Status reads 1,1 with no busy read: done with code 0 after exactly 2 polls.
- io_cmd_ready_i held low 5 cycles during step 2: io_cmd_o holds offset 0x080 and data len stable; no step skip.
- BP_CACC_SEQ_TIMEOUT_EN defined, max_polls_p=4, status always 0: 4 polls, then done_err_o=2.
- reset_n_i asserted during GAP, then released: IDLE, job_ready_o=1, no stray command; a following legal job completes normally.
